// File: rtl/encoder_8to3_seq.sv
// ---------------------------------------------------------------------------
// encoder_8to3_seq
//   Sequential priority encoder. Captures an 8-bit multi-hot request vector
//   and emits the index of every set bit, one beat per accepted handshake,
//   in priority order. An all-zero vector produces a single flagged beat.
//
// Parameters
//   HI_FIRST   1: bit 7 served first, 0: bit 0 served first
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_d carries a request vector
//   in_ready   block accepts a vector this cycle (registered)
//   in_d       8-bit request vector, bit i requests code i
//   out_valid  out_code/out_last/out_zero are valid (registered)
//   out_ready  consumer accepts the current code
//   out_code   index of the highest-priority pending bit (registered)
//   out_last   current beat is the final beat of the vector (registered)
//   out_zero   captured vector was all zeros (registered)
//   out_count  popcount of the captured vector, held until next capture
// ---------------------------------------------------------------------------
module encoder_8to3_seq #(
    parameter bit HI_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_d,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_code,
    output logic       out_last,
    output logic       out_zero,
    output logic [3:0] out_count
);

    localparam int unsigned VEC_W  = 8;
    localparam int unsigned CODE_W = 3;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_e;

    // Index of the first set bit in priority order; 0 for an empty vector.
    function automatic logic [CODE_W-1:0] prio_code(input logic [VEC_W-1:0] v);
        logic [CODE_W-1:0] code;
        code = '0;
        if (HI_FIRST) begin
            // Ascending scan: the last hit is the highest set bit.
            for (int i = 0; i < int'(VEC_W); i++) begin
                if (v[i]) code = CODE_W'(i);
            end
        end else begin
            // Descending scan: the last hit is the lowest set bit.
            for (int i = int'(VEC_W) - 1; i >= 0; i--) begin
                if (v[i]) code = CODE_W'(i);
            end
        end
        return code;
    endfunction

    // Number of set bits in the vector.
    function automatic logic [CNT_W-1:0] pop_count(input logic [VEC_W-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(VEC_W); i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // True when at most one bit is set; covers both "one left" and zero vector.
    function automatic logic at_most_one(input logic [VEC_W-1:0] v);
        return ((v & (v - VEC_W'(1))) == '0);
    endfunction

    state_e              state_q,   state_d;
    logic [VEC_W-1:0]    pending_q, pending_d;
    logic [CNT_W-1:0]    count_q,   count_d;
    logic [CODE_W-1:0]   code_q,    code_d;
    logic                last_q,    last_d;
    logic                zero_q,    zero_d;
    logic                valid_q,   valid_d;
    logic                ready_q,   ready_d;
    logic [VEC_W-1:0]    served_vec;

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        count_d    = count_q;
        code_d     = code_q;
        last_d     = last_q;
        zero_d     = zero_q;
        valid_d    = valid_q;
        ready_d    = ready_q;
        // Pending vector with the currently presented bit removed.
        served_vec = pending_q & ~(VEC_W'(1) << code_q);

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d   = S_EMIT;
                    pending_d = in_d;
                    count_d   = pop_count(in_d);
                    code_d    = prio_code(in_d);
                    last_d    = at_most_one(in_d);
                    zero_d    = (in_d == '0);
                    valid_d   = 1'b1;
                    ready_d   = 1'b0;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (last_q) begin
                        // Final beat taken: one bubble cycle in IDLE follows.
                        state_d   = S_IDLE;
                        pending_d = '0;
                        code_d    = '0;
                        last_d    = 1'b0;
                        zero_d    = 1'b0;
                        valid_d   = 1'b0;
                        ready_d   = 1'b1;
                    end else begin
                        pending_d = served_vec;
                        code_d    = prio_code(served_vec);
                        last_d    = at_most_one(served_vec);
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                pending_d = '0;
                code_d    = '0;
                last_d    = 1'b0;
                zero_d    = 1'b0;
                valid_d   = 1'b0;
                ready_d   = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            count_q   <= '0;
            code_q    <= '0;
            last_q    <= 1'b0;
            zero_q    <= 1'b0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            code_q    <= code_d;
            last_q    <= last_d;
            zero_q    <= zero_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_code  = code_q;
    assign out_last  = last_q;
    assign out_zero  = zero_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// ---------------------------------------------------------------------------
// tb_encoder_8to3_seq
//   Directed bench for encoder_8to3_seq. Two instances (HI_FIRST=1 and
//   HI_FIRST=0) share all inputs; expected codes are hand-written per test.
// ---------------------------------------------------------------------------
module tb_encoder_8to3_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_d;
    logic       out_ready;

    logic       hi_in_ready, hi_out_valid, hi_out_last, hi_out_zero;
    logic [2:0] hi_out_code;
    logic [3:0] hi_out_count;
    logic       lo_in_ready, lo_out_valid, lo_out_last, lo_out_zero;
    logic [2:0] lo_out_code;
    logic [3:0] lo_out_count;

    int errors;
    int checks;

    encoder_8to3_seq #(.HI_FIRST(1'b1)) dut_hi (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (hi_in_ready),
        .in_d      (in_d),
        .out_valid (hi_out_valid),
        .out_ready (out_ready),
        .out_code  (hi_out_code),
        .out_last  (hi_out_last),
        .out_zero  (hi_out_zero),
        .out_count (hi_out_count)
    );

    encoder_8to3_seq #(.HI_FIRST(1'b0)) dut_lo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (lo_in_ready),
        .in_d      (in_d),
        .out_valid (lo_out_valid),
        .out_ready (out_ready),
        .out_code  (lo_out_code),
        .out_last  (lo_out_last),
        .out_zero  (lo_out_zero),
        .out_count (lo_out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Capture v and drain it with out_ready=1. exp_hi/exp_lo hold 3-bit codes,
    // beat 0 in the low bits. Ends in the bubble cycle after the burst.
    task automatic run_burst(input logic [7:0] v, input int n, input logic [23:0] exp_hi,
                             input logic [23:0] exp_lo, input logic [3:0] exp_cnt,
                             input logic exp_zero);
        in_valid  = 1'b1;
        in_d      = v;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int b = 0; b < n; b++) begin
            check("hi_valid", 32'(hi_out_valid), 32'd1);
            check("hi_ready", 32'(hi_in_ready), 32'd0);
            check("hi_code",  32'(hi_out_code), 32'(exp_hi[3*b +: 3]));
            check("lo_code",  32'(lo_out_code), 32'(exp_lo[3*b +: 3]));
            check("hi_last",  32'(hi_out_last), 32'(b == n - 1));
            check("lo_last",  32'(lo_out_last), 32'(b == n - 1));
            check("hi_zero",  32'(hi_out_zero), 32'(exp_zero));
            check("hi_count", 32'(hi_out_count), 32'(exp_cnt));
            check("lo_count", 32'(lo_out_count), 32'(exp_cnt));
            step();
        end
        check("bubble_hi_valid", 32'(hi_out_valid), 32'd0);
        check("bubble_lo_valid", 32'(lo_out_valid), 32'd0);
        check("bubble_hi_ready", 32'(hi_in_ready), 32'd1);
        check("bubble_lo_ready", 32'(lo_in_ready), 32'd1);
        check("idle_count_hold", 32'(hi_out_count), 32'(exp_cnt));
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        in_valid  = 1'b0;
        in_d      = 8'h00;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #2;

        // Reset values
        check("rst_ready", 32'(hi_in_ready), 32'd1);
        check("rst_valid", 32'(hi_out_valid), 32'd0);
        check("rst_code",  32'(hi_out_code), 32'd0);
        check("rst_last",  32'(hi_out_last), 32'd0);
        check("rst_zero",  32'(hi_out_zero), 32'd0);
        check("rst_count", 32'(hi_out_count), 32'd0);

        // in_valid held during reset must not capture before release
        in_valid = 1'b1;
        in_d     = 8'h08;
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("pre_edge_valid", 32'(hi_out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        check("first_cap_valid", 32'(hi_out_valid), 32'd1);
        check("first_cap_code",  32'(hi_out_code), 32'd3);
        check("first_cap_last",  32'(hi_out_last), 32'd1);
        out_ready = 1'b1;
        step();
        check("first_cap_done", 32'(hi_out_valid), 32'd0);

        // Mixed vector, both priority orders
        run_burst(8'b1010_0100, 3, 24'({3'd2, 3'd5, 3'd7}), 24'({3'd7, 3'd5, 3'd2}), 4'd3, 1'b0);

        // Zero vector
        run_burst(8'h00, 1, 24'd0, 24'd0, 4'd0, 1'b1);
        check("zero_flag_cleared", 32'(hi_out_zero), 32'd0);

        // Back-to-back single-bit vectors, one bubble between
        run_burst(8'h10, 1, 24'd4, 24'd4, 4'd1, 1'b0);
        run_burst(8'h02, 1, 24'd1, 24'd1, 4'd1, 1'b0);

        // Full vector with out_ready toggling; in_valid pulses must be ignored
        in_valid  = 1'b1;
        in_d      = 8'hFF;
        out_ready = 1'b1;
        step();
        for (int b = 0; b < 8; b++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_d      = 8'h0F;
            check("ff_hi_code", 32'(hi_out_code), 32'(7 - b));
            check("ff_lo_code", 32'(lo_out_code), 32'(b));
            check("ff_hi_last", 32'(hi_out_last), 32'(b == 7));
            step();
            check("ff_stall_valid", 32'(hi_out_valid), 32'd1);
            check("ff_stall_code",  32'(hi_out_code), 32'(7 - b));
            check("ff_stall_last",  32'(hi_out_last), 32'(b == 7));
            check("ff_stall_zero",  32'(hi_out_zero), 32'd0);
            check("ff_count",       32'(hi_out_count), 32'd8);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            step();
        end
        check("ff_end_valid", 32'(hi_out_valid), 32'd0);
        check("ff_end_ready", 32'(hi_in_ready), 32'd1);
        check("ff_end_count", 32'(hi_out_count), 32'd8);

        // Reset mid-burst discards remaining codes
        in_valid  = 1'b1;
        in_d      = 8'h81;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("r81_first_code", 32'(hi_out_code), 32'd7);
        check("r81_count",      32'(hi_out_count), 32'd2);
        step();
        check("r81_second_code", 32'(hi_out_code), 32'd0);
        check("r81_second_valid", 32'(hi_out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(hi_out_valid), 32'd0);
        check("async_ready", 32'(hi_in_ready), 32'd1);
        check("async_count", 32'(hi_out_count), 32'd0);
        check("async_last",  32'(hi_out_last), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("post_rst_valid", 32'(hi_out_valid), 32'd0);
            check("post_rst_ready", 32'(hi_in_ready), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
